reg_file_sb: RTL and testbench

- Parametrised successor to the team's 8x8 register file.
- Configurable data width and depth, NUM_RD independent read ports, and registered reads with write-through bypass.
- Optional hardwired-zero register 0.
- Per-register pending-write scoreboard (busy bits), so the MCU control unit can stall on RAW hazards from multi-cycle ops.
- Sits between decode (read/reserve) and writeback (write) in the processor datapath.

---
 rtl/reg_file_sb.sv | 91 +++++++++
 tb/tb_reg_file_sb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised register file with registered multi-port reads,
// write-through bypass and a per-register pending-write scoreboard.
module reg_file_sb #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     reg_write,
   input  logic [ADDR_W-1:0]        write_addr,
   input  logic [DATA_W-1:0]        write_data,
   input  logic                     reserve_en,
   input  logic [ADDR_W-1:0]        reserve_addr,
   input  logic [NUM_RD-1:0]        read_en,
   input  logic [NUM_RD*ADDR_W-1:0] read_addr,
   output logic [NUM_RD*DATA_W-1:0] read_data,
   output logic [NUM_RD-1:0]        read_busy,
   output logic [2**ADDR_W-1:0]     busy_vec
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]        r_regs [DEPTH];
   logic [DEPTH-1:0]         r_busy;
   logic [NUM_RD*DATA_W-1:0] r_rd_data;
   logic [NUM_RD-1:0]        r_rd_busy;
   logic [DEPTH-1:0]         w_busy_nxt;
   logic                     w_wr_ok;
   logic                     w_rsv_ok;

   assign w_wr_ok  = reg_write &
                     ~(ZERO_REG & (write_addr == '0));
   assign w_rsv_ok = reserve_en &
                     ~(ZERO_REG & (reserve_addr == '0));

   // A new reservation outranks a completing write to the same register
   always_comb begin
      w_busy_nxt = r_busy;
      for (int r = 0; r < DEPTH; r++) begin
         if (w_rsv_ok && reserve_addr == ADDR_W'(r))
            w_busy_nxt[r] = 1'b1;
         else if (w_wr_ok && write_addr == ADDR_W'(r))
            w_busy_nxt[r] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++)
            r_regs[r] <= '0;
         r_busy <= '0;
      end else begin
         if (w_wr_ok)
            r_regs[write_addr] <= write_data;
         r_busy <= w_busy_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
         r_rd_busy <= '0;
      end else begin
         for (int i = 0; i < NUM_RD; i++) begin
            if (read_en[i]) begin
               if (ZERO_REG &&
                   read_addr[i*ADDR_W +: ADDR_W] == '0) begin
                  r_rd_data[i*DATA_W +: DATA_W] <= '0;
                  r_rd_busy[i] <= 1'b0;
               end else begin
                  if (w_wr_ok && write_addr ==
                      read_addr[i*ADDR_W +: ADDR_W])
                     r_rd_data[i*DATA_W +: DATA_W] <= write_data;
                  else
                     r_rd_data[i*DATA_W +: DATA_W] <=
                        r_regs[read_addr[i*ADDR_W +: ADDR_W]];
                  r_rd_busy[i] <=
                     w_busy_nxt[read_addr[i*ADDR_W +: ADDR_W]];
               end
            end
         end
      end
   end

   assign read_data = r_rd_data;
   assign read_busy = r_rd_busy;
   assign busy_vec  = r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: plain instance plus a ZERO_REG=1
// instance, both driven by the same stimulus.
module tb_reg_file_sb;

   logic        clk;
   logic        rst_n;
   logic        reg_write;
   logic [2:0]  write_addr;
   logic [7:0]  write_data;
   logic        reserve_en;
   logic [2:0]  reserve_addr;
   logic [1:0]  read_en;
   logic [2:0]  ra0, ra1;
   logic [5:0]  read_addr;
   logic [15:0] rd, zrd;
   logic [1:0]  rbusy, zrbusy;
   logic [7:0]  bvec, zbvec;

   int n_vec = 0;
   int n_err = 0;

   assign read_addr = {ra1, ra0};

   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .reg_write(reg_write), .write_addr(write_addr),
      .write_data(write_data),
      .reserve_en(reserve_en), .reserve_addr(reserve_addr),
      .read_en(read_en), .read_addr(read_addr),
      .read_data(rd), .read_busy(rbusy), .busy_vec(bvec)
   );

   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1)) u_dutz (
      .clk(clk), .rst_n(rst_n),
      .reg_write(reg_write), .write_addr(write_addr),
      .write_data(write_data),
      .reserve_en(reserve_en), .reserve_addr(reserve_addr),
      .read_en(read_en), .read_addr(read_addr),
      .read_data(zrd), .read_busy(zrbusy), .busy_vec(zbvec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reg_write  = 1'b0;
      reserve_en = 1'b0;
      read_en    = 2'b00;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      reg_write  = 1'b1;
      write_addr = a;
      write_data = d;
   endtask

   task automatic rsv(input logic [2:0] a);
      reserve_en   = 1'b1;
      reserve_addr = a;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      write_addr = '0; write_data = '0;
      reserve_addr = '0; ra0 = '0; ra1 = '0;
      tick();
      tick();
      chk("rst_rd", rd, 16'h0000);
      chk("rst_bvec", bvec, 8'h00);
      chk("rst_rbusy", rbusy, 2'b00);
      rst_n = 1'b1;

      // populate r3, reserve r1, read r3 back
      wr(3'd3, 8'hA5); rsv(3'd1);
      tick();
      idle(); read_en = 2'b01; ra0 = 3'd3;
      tick();
      chk("pre_rst_rd0", rd[7:0], 8'hA5);
      chk("pre_rst_bvec", bvec, 8'h02);

      // mid-cycle reset clears outputs immediately
      #2 rst_n = 1'b0;
      #1;
      chk("async_rd", rd, 16'h0000);
      chk("async_bvec", bvec, 8'h00);
      chk("async_rbusy", rbusy, 2'b00);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_r3", rd[7:0], 8'h00);

      // basic write then dual-port read
      idle(); wr(3'd5, 8'h3C);
      tick();
      idle(); read_en = 2'b11; ra0 = 3'd5; ra1 = 3'd5;
      tick();
      chk("basic_rd", rd, 16'h3C3C);
      chk("basic_rbusy", rbusy, 2'b00);

      // bypass on port1; port0 holds
      idle(); wr(3'd2, 8'h11);
      tick();
      wr(3'd2, 8'h7E); read_en = 2'b10; ra1 = 3'd2;
      tick();
      chk("bypass_rd1", rd[15:8], 8'h7E);
      chk("hold_rd0", rd[7:0], 8'h3C);

      // scoreboard reserve, then write clears with same-edge read
      idle(); rsv(3'd4);
      tick();
      idle();
      chk("sb_bvec_set", bvec, 8'h10);
      read_en = 2'b01; ra0 = 3'd4;
      tick();
      chk("sb_rbusy_set", rbusy[0], 1'b1);
      wr(3'd4, 8'h55);
      tick();
      chk("sb_wr_rd0", rd[7:0], 8'h55);
      chk("sb_wr_rbusy", rbusy[0], 1'b0);
      chk("sb_bvec_clr", bvec, 8'h00);

      // simultaneous reserve and write on busy r6
      idle(); rsv(3'd6);
      tick();
      wr(3'd6, 8'h99); rsv(3'd6);
      tick();
      idle();
      chk("rw_bvec", bvec, 8'h40);
      read_en = 2'b10; ra1 = 3'd6;
      tick();
      chk("rw_rd1", rd[15:8], 8'h99);
      chk("rw_rbusy1", rbusy[1], 1'b1);

      // reserve and read same edge: read_busy sees next state
      idle(); rsv(3'd7); read_en = 2'b01; ra0 = 3'd7;
      tick();
      chk("rsv_rd_rbusy", rbusy, 2'b11);
      chk("rsv_rd_bvec", bvec, 8'hC0);

      // r0 writes/reserves: ignored only with ZERO_REG
      idle(); wr(3'd0, 8'hFF); rsv(3'd0);
      tick();
      idle();
      chk("z_bvec", zbvec, 8'hC0);
      chk("nz_bvec", bvec, 8'hC1);
      read_en = 2'b01; ra0 = 3'd0;
      tick();
      chk("z_rd0", zrd[7:0], 8'h00);
      chk("z_rbusy0", zrbusy[0], 1'b0);
      chk("nz_rd0", rd[7:0], 8'hFF);
      chk("nz_rbusy0", rbusy[0], 1'b1);
      idle(); wr(3'd7, 8'hC3); read_en = 2'b10; ra1 = 3'd7;
      tick();
      idle();
      chk("z_r7_rd1", zrd[15:8], 8'hC3);
      chk("z_r7_rbusy1", zrbusy[1], 1'b0);
      chk("z_r7_bvec", zbvec, 8'h40);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
